// File: rtl/pll_lock_reset_seq.sv
// Power-up and lock sequencer for the CCC/PLL feeding the IOD receive path.
// Optional feature macro: LOCK_LOSS_RECOVERY_EN (lock loss in RUN re-sequences instead of failing).
module pll_lock_reset_seq #(
  parameter int PWRDN_CYCLES = 16,
  parameter int LOCK_FILTER  = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int RELEASE_GAP  = 8,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  output logic       PLL_POWERDOWN_N,
  output logic       IOD_RESET_N,
  output logic       FAB_RESET_N,
  output logic       TRAIN_START,
  output logic       READY,
  output logic       LOCK_FAIL,
  output logic [1:0] RETRY_CNT
);

  typedef enum logic [2:0] {
    ST_PWRDN     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_REL_IOD   = 3'd3,
    ST_REL_FAB   = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAIL      = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] PWRDN_LAST   = CNT_W'(PWRDN_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP - 1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [1:0]       retry_r, retry_nxt_s, retry_inc_s;
  logic             lock_meta_r, lock_s_r;
  logic             pwrdn_n_r, iod_rst_n_r, fab_rst_n_r, train_r, ready_r, fail_r;
  logic             pwrdn_n_s, iod_rst_n_s, fab_rst_n_s, train_s, ready_s, fail_s;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_meta_r <= 1'b0;
      lock_s_r    <= 1'b0;
    end else begin
      lock_meta_r <= PLL_LOCK;
      lock_s_r    <= lock_meta_r;
    end
  end

  // Next-state, shared counter and retry bookkeeping
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    retry_nxt_s = retry_r;
    retry_inc_s = retry_r + 2'd1;
    case (state_r)
      ST_PWRDN: begin
        if (cnt_r == PWRDN_LAST) begin
          state_nxt_s = ST_WAIT_LOCK;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_PWRDN;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock seen on the timeout cycle wins over the retry
        if (lock_s_r) begin
          state_nxt_s = ST_FILTER;
          cnt_nxt_s   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt_r == TIMEOUT_LAST) begin
          retry_nxt_s = retry_inc_s;
          cnt_nxt_s   = '0;
          if (retry_inc_s == RETRY_LIMIT) begin
            state_nxt_s = ST_FAIL;
          end else begin
            state_nxt_s = ST_PWRDN;
          end
        end else begin
          state_nxt_s = ST_WAIT_LOCK;
        end
      end
      ST_FILTER: begin
        if (!lock_s_r) begin
          state_nxt_s = ST_WAIT_LOCK;
          cnt_nxt_s   = '0;
        end else if (cnt_r == FILTER_LAST) begin
          state_nxt_s = ST_REL_IOD;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_FILTER;
        end
      end
      ST_REL_IOD: begin
        if (cnt_r == GAP_LAST) begin
          state_nxt_s = ST_REL_FAB;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_REL_IOD;
        end
      end
      ST_REL_FAB: begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = '0;
        retry_nxt_s = 2'd0;
      end
      ST_RUN: begin
        cnt_nxt_s = '0;
        if (!lock_s_r) begin
`ifdef LOCK_LOSS_RECOVERY_EN
          state_nxt_s = ST_PWRDN;
          retry_nxt_s = 2'd0;
`else
          state_nxt_s = ST_FAIL;
`endif
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FAIL: begin
        state_nxt_s = ST_FAIL;
        cnt_nxt_s   = '0;
      end
      default: begin
        state_nxt_s = ST_PWRDN;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track the state register
  always_comb begin
    pwrdn_n_s   = 1'b0;
    iod_rst_n_s = 1'b0;
    fab_rst_n_s = 1'b0;
    train_s     = 1'b0;
    ready_s     = 1'b0;
    fail_s      = 1'b0;
    case (state_nxt_s)
      ST_PWRDN:     pwrdn_n_s = 1'b0;
      ST_WAIT_LOCK: pwrdn_n_s = 1'b1;
      ST_FILTER:    pwrdn_n_s = 1'b1;
      ST_REL_IOD: begin
        pwrdn_n_s   = 1'b1;
        iod_rst_n_s = 1'b1;
      end
      ST_REL_FAB: begin
        pwrdn_n_s   = 1'b1;
        iod_rst_n_s = 1'b1;
        fab_rst_n_s = 1'b1;
        train_s     = 1'b1;
      end
      ST_RUN: begin
        pwrdn_n_s   = 1'b1;
        iod_rst_n_s = 1'b1;
        fab_rst_n_s = 1'b1;
        ready_s     = 1'b1;
      end
      ST_FAIL:      fail_s = 1'b1;
      default:      pwrdn_n_s = 1'b0;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= ST_PWRDN;
      cnt_r       <= '0;
      retry_r     <= 2'd0;
      pwrdn_n_r   <= 1'b0;
      iod_rst_n_r <= 1'b0;
      fab_rst_n_r <= 1'b0;
      train_r     <= 1'b0;
      ready_r     <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      retry_r     <= retry_nxt_s;
      pwrdn_n_r   <= pwrdn_n_s;
      iod_rst_n_r <= iod_rst_n_s;
      fab_rst_n_r <= fab_rst_n_s;
      train_r     <= train_s;
      ready_r     <= ready_s;
      fail_r      <= fail_s;
    end
  end

  assign PLL_POWERDOWN_N = pwrdn_n_r;
  assign IOD_RESET_N     = iod_rst_n_r;
  assign FAB_RESET_N     = fab_rst_n_r;
  assign TRAIN_START     = train_r;
  assign READY           = ready_r;
  assign LOCK_FAIL       = fail_r;
  assign RETRY_CNT       = retry_r;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq with small timing parameters.
// Cycle c counts rising edges after RESET release; outputs are sampled 1 ns after each edge.
module tb_pll_lock_reset_seq;

  logic       CLK;
  logic       RESET;
  logic       PLL_LOCK;
  logic       PLL_POWERDOWN_N;
  logic       IOD_RESET_N;
  logic       FAB_RESET_N;
  logic       TRAIN_START;
  logic       READY;
  logic       LOCK_FAIL;
  logic [1:0] RETRY_CNT;

  int total;
  int bad;

  pll_lock_reset_seq #(
    .PWRDN_CYCLES(4),
    .LOCK_FILTER (8),
    .LOCK_TIMEOUT(32),
    .RELEASE_GAP (2),
    .MAX_RETRIES (2),
    .CNT_W       (16)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .PLL_LOCK       (PLL_LOCK),
    .PLL_POWERDOWN_N(PLL_POWERDOWN_N),
    .IOD_RESET_N    (IOD_RESET_N),
    .FAB_RESET_N    (FAB_RESET_N),
    .TRAIN_START    (TRAIN_START),
    .READY          (READY),
    .LOCK_FAIL      (LOCK_FAIL),
    .RETRY_CNT      (RETRY_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic hold_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    RESET    = 1'b1;
    PLL_LOCK = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    obs = {PLL_POWERDOWN_N, IOD_RESET_N, FAB_RESET_N, TRAIN_START, READY, LOCK_FAIL, RETRY_CNT};
    total++;
    if (obs !== 8'b0000_0000) begin
      bad++;
      $display("FAIL reset_values got=%b want=%b", obs, 8'b0000_0000);
    end
    PLL_LOCK = 1'b0;
    RESET    = 1'b0;
  endtask

  // Lock rises 10 cycles after powerdown exit (c4); first synced high lands at c17
  task automatic test_clean_lock();
    logic [7:0] obs, exp;
    hold_reset();
    for (int c = 0; c <= 32; c++) begin
      exp = {1'(c >= 4), 1'(c >= 24), 1'(c >= 26), 1'(c == 26), 1'(c >= 27), 1'b0, 2'd0};
      obs = {PLL_POWERDOWN_N, IOD_RESET_N, FAB_RESET_N, TRAIN_START, READY, LOCK_FAIL, RETRY_CNT};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL clean_lock c=%0d got=%b want=%b", c, obs, exp);
      end
      PLL_LOCK = (c >= 14);
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_no_lock();
    logic [7:0] obs, exp;
    logic [1:0] rc;
    PLL_LOCK = 1'b0;
    hold_reset();
    for (int c = 0; c <= 85; c++) begin
      rc  = (c < 36) ? 2'd0 : ((c < 72) ? 2'd1 : 2'd2);
      exp = {1'((c >= 4 && c < 36) || (c >= 40 && c < 72)), 4'b0000, 1'(c >= 72), rc};
      obs = {PLL_POWERDOWN_N, IOD_RESET_N, FAB_RESET_N, TRAIN_START, READY, LOCK_FAIL, RETRY_CNT};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL no_lock c=%0d got=%b want=%b", c, obs, exp);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  // Five highs, one low, then steady: the filter must restart on the low
  task automatic test_glitchy_lock();
    logic [7:0] obs, exp;
    hold_reset();
    for (int c = 0; c <= 26; c++) begin
      exp = {1'(c >= 4), 1'(c >= 20), 1'(c >= 22), 1'(c == 22), 1'(c >= 23), 1'b0, 2'd0};
      obs = {PLL_POWERDOWN_N, IOD_RESET_N, FAB_RESET_N, TRAIN_START, READY, LOCK_FAIL, RETRY_CNT};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL glitchy_lock c=%0d got=%b want=%b", c, obs, exp);
      end
      PLL_LOCK = (c >= 4 && c <= 8) || (c >= 10);
      @(posedge CLK);
      #1;
    end
    PLL_LOCK = 1'b0;
  endtask

  // One-cycle lock drop in RUN, seen by the FSM at c33
  task automatic test_lock_loss();
    logic [7:0] obs, exp;
    hold_reset();
    for (int c = 0; c <= 55; c++) begin
`ifdef LOCK_LOSS_RECOVERY_EN
      exp = {1'(c >= 4 && !(c >= 33 && c < 37)),
             1'((c >= 24 && c < 33) || c >= 45),
             1'((c >= 26 && c < 33) || c >= 47),
             1'(c == 26 || c == 47),
             1'((c >= 27 && c < 33) || c >= 48),
             1'b0, 2'd0};
`else
      exp = {1'(c >= 4 && c < 33), 1'(c >= 24 && c < 33), 1'(c >= 26 && c < 33),
             1'(c == 26), 1'(c >= 27 && c < 33), 1'(c >= 33), 2'd0};
`endif
      obs = {PLL_POWERDOWN_N, IOD_RESET_N, FAB_RESET_N, TRAIN_START, READY, LOCK_FAIL, RETRY_CNT};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL lock_loss c=%0d got=%b want=%b", c, obs, exp);
      end
      PLL_LOCK = (c >= 14) && (c != 30);
      @(posedge CLK);
      #1;
    end
    PLL_LOCK = 1'b0;
  endtask

  task automatic test_reset_mid_release();
    logic [7:0] obs, exp;
    hold_reset();
    for (int c = 0; c <= 25; c++) begin
      PLL_LOCK = (c >= 14);
      @(posedge CLK);
      #1;
    end
    total++;
    if (IOD_RESET_N !== 1'b1) begin
      bad++;
      $display("FAIL mid_release_entry got=%b want=1", IOD_RESET_N);
    end
    #2;
    RESET = 1'b1;
    #1;
    obs = {PLL_POWERDOWN_N, IOD_RESET_N, FAB_RESET_N, TRAIN_START, READY, LOCK_FAIL, RETRY_CNT};
    total++;
    if (obs !== 8'b0000_0000) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b", obs, 8'b0000_0000);
    end
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    for (int c = 0; c <= 18; c++) begin
      exp = {1'(c >= 4), 1'(c >= 12), 1'(c >= 14), 1'(c == 14), 1'(c >= 15), 1'b0, 2'd0};
      obs = {PLL_POWERDOWN_N, IOD_RESET_N, FAB_RESET_N, TRAIN_START, READY, LOCK_FAIL, RETRY_CNT};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reseq_after_reset c=%0d got=%b want=%b", c, obs, exp);
      end
      @(posedge CLK);
      #1;
    end
    PLL_LOCK = 1'b0;
  endtask

  // First attempt times out at c36, lock is applied during the second attempt
  task automatic test_retry_success();
    logic [7:0] obs, exp;
    hold_reset();
    for (int c = 0; c <= 58; c++) begin
      exp = {1'((c >= 4 && c < 36) || c >= 40), 1'(c >= 50), 1'(c >= 52), 1'(c == 52),
             1'(c >= 53), 1'b0, ((c >= 36 && c < 53) ? 2'd1 : 2'd0)};
      obs = {PLL_POWERDOWN_N, IOD_RESET_N, FAB_RESET_N, TRAIN_START, READY, LOCK_FAIL, RETRY_CNT};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL retry_success c=%0d got=%b want=%b", c, obs, exp);
      end
      PLL_LOCK = (c >= 40);
      @(posedge CLK);
      #1;
    end
    PLL_LOCK = 1'b0;
  endtask

  // Synced lock arrives exactly on the timeout cycle (c36): no retry may be taken
  task automatic test_timeout_boundary();
    logic [7:0] obs, exp;
    hold_reset();
    for (int c = 0; c <= 50; c++) begin
      exp = {1'(c >= 4), 1'(c >= 43), 1'(c >= 45), 1'(c == 45), 1'(c >= 46), 1'b0, 2'd0};
      obs = {PLL_POWERDOWN_N, IOD_RESET_N, FAB_RESET_N, TRAIN_START, READY, LOCK_FAIL, RETRY_CNT};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL timeout_boundary c=%0d got=%b want=%b", c, obs, exp);
      end
      PLL_LOCK = (c >= 33);
      @(posedge CLK);
      #1;
    end
    PLL_LOCK = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    RESET    = 1'b1;
    PLL_LOCK = 1'b0;
    test_reset();
    test_clean_lock();
    test_no_lock();
    test_glitchy_lock();
    test_lock_loss();
    test_reset_mid_release();
    test_retry_success();
    test_timeout_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
